// File: rtl/sqrt_sync_bridge_if.sv
// Stream bundle for sqrt_sync_bridge: operand stream in, result stream out.
//   in_valid/in_ready/in_data     operand handshake (producer -> bridge)
//   res_valid/res_ready/res_data  result handshake  (bridge -> consumer)
// master: producer/consumer side; slave: bridge side.
interface sqrt_sync_bridge_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/sqrt_sync_bridge.sv
// Clocked front end for a self-timed sqrt core using a four-phase req/fin
// handshake with bundled data. One operand in flight at a time.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           operand/result valid-ready streams (slave side)
//   busy          high whenever the FSM is not idle
//   timeout_err   sticky, a fin edge took TIMEOUT cycles or more (0 disables)
//   sq_req/sq_in  registered request and operand towards the core
//   sq_fin/sq_out asynchronous completion and root from the core
module sqrt_sync_bridge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    sqrt_sync_bridge_if.slave bus,
    output logic             busy,
    output logic             timeout_err,
    output logic             sq_req,
    output logic [WIDTH-1:0] sq_in,
    input  logic             sq_fin,
    input  logic [WIDTH-1:0] sq_out
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned VLD_W = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic             TO_EN      = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       sq_in_q, sq_in_d;
    logic                   sq_req_q, sq_req_d;
    logic [WIDTH-1:0]       res_data_q, res_data_d;
    logic                   res_valid_q, res_valid_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   busy_q, busy_d;
    logic                   in_ready_q, in_ready_d;
    logic [SYNC_STAGES-1:0] fin_sync_q;
    logic [VLD_W-1:0]       sync_vld_q;
    logic                   fin_s;
    logic                   fin_s_next;
    logic                   fin_s_next_vld;
    logic                   wait_tick;

    assign fin_s          = fin_sync_q[SYNC_STAGES-1];
    // Value fin_s takes after the coming edge, so in_ready can be registered exactly.
    assign fin_s_next     = fin_sync_q[SYNC_STAGES-2];
    // The synchroniser is cleared by reset; its output is only trusted once refilled
    // from sq_fin, otherwise a fin still high from before reset would look low.
    assign fin_s_next_vld = sync_vld_q[VLD_W-1];

    // fin synchroniser and its post-reset fill tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_sync_q <= '0;
            sync_vld_q <= '0;
        end else begin
            fin_sync_q <= {fin_sync_q[SYNC_STAGES-2:0], sq_fin};
            sync_vld_q <= VLD_W'({sync_vld_q, 1'b1});
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sq_in_q       <= '0;
            sq_req_q      <= 1'b0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sq_in_q       <= sq_in_d;
            sq_req_q      <= sq_req_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sq_in_d       = sq_in_q;
        sq_req_d      = sq_req_q;
        res_data_d    = res_data_q;
        res_valid_d   = res_valid_q;
        timeout_err_d = timeout_err_q;
        wait_tick     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sq_in_d = bus.in_data;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    sq_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (fin_s) begin
                    res_data_d = sq_out;
                    sq_req_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT_LO;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!fin_s) begin
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout only flags; the handshake keeps waiting. Counter saturates.
        if (wait_tick) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (TO_EN && (cnt_q == TO_LAST)) begin
                timeout_err_d = 1'b1;
            end
        end

        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE) && fin_s_next_vld && !fin_s_next;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign sq_req        = sq_req_q;
    assign sq_in         = sq_in_q;

endmodule

// File: tb/tb_sqrt_sync_bridge.sv
// Bench for sqrt_sync_bridge: behavioural self-timed sqrt core with random
// fin delays, integer-sqrt reference, scenario tasks run in sequence.
module tb_sqrt_sync_bridge;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned SETUP_CYC   = 1;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 64;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_HOLD   = 2;

    logic             clk;
    logic             rst;
    logic             busy;
    logic             timeout_err;
    logic             sq_req;
    logic [WIDTH-1:0] sq_in;
    logic             sq_fin;
    logic [WIDTH-1:0] sq_out;

    int vectors;
    int miscompares;
    int mode;
    logic release_fin;

    sqrt_sync_bridge_if #(.WIDTH(WIDTH)) bus ();

    sqrt_sync_bridge #(
        .WIDTH      (WIDTH),
        .SETUP_CYC  (SETUP_CYC),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sq_req     (sq_req),
        .sq_in      (sq_in),
        .sq_fin     (sq_fin),
        .sq_out     (sq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: largest r with r*r <= v, by bisection.
    function automatic logic [31:0] isqrt(input logic [31:0] v);
        longint unsigned lo;
        longint unsigned hi;
        longint unsigned mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid;
        end
        return 32'(lo);
    endfunction

    // Behavioural async core: fin follows req after 3..40 time units;
    // sq_out is scrambled once fin has dropped.
    initial begin
        sq_fin = 1'b0;
        sq_out = '0;
        forever begin
            @(posedge sq_req);
            if (mode == MODE_NORMAL) begin
                #($urandom_range(40, 3));
                sq_out = isqrt(sq_in);
                sq_fin = 1'b1;
                @(negedge sq_req);
                #($urandom_range(40, 3));
                sq_fin = 1'b0;
                #1;
                sq_out = $urandom;
            end else if (mode == MODE_HOLD) begin
                #($urandom_range(40, 3));
                sq_out = isqrt(sq_in);
                sq_fin = 1'b1;
                wait (release_fin);
                sq_fin = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for in_ready; returns 1 if seen.
    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_wait: got %b expected 1", bus.in_ready);
        end
    endtask

    // One full transaction with bp cycles of result backpressure.
    task automatic run_op(input logic [31:0] d, input int bp);
        logic [31:0] exp;
        logic        ok;
        int          n;
        exp = isqrt(d);
        wait_ready(ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        // accept -> sq_req after SETUP_CYC+1 edges
        n = 0;
        while (sq_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== SETUP_CYC + 1) begin
            miscompares++;
            $display("FAIL req_latency: got %0d expected %0d", n, SETUP_CYC + 1);
        end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 100) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_phase: in_ready=%b busy=%b expected 0/1", bus.in_ready, busy);
            end
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL res_valid_wait: got %b expected 1", bus.res_valid);
            return;
        end
        vectors++;
        if (bus.res_data !== exp) begin
            miscompares++;
            $display("FAIL res_data(%0h): got %0d expected %0d", d, bus.res_data, exp);
        end
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure: valid=%b data=%0d in_ready=%b expected 1/%0d/0",
                         bus.res_valid, bus.res_data, bus.in_ready, exp);
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vectors++;
        if (bus.res_valid !== 1'b0 || sq_req !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_consume: valid=%b req=%b terr=%b busy=%b expected 0/0/0/0",
                     bus.res_valid, sq_req, timeout_err, busy);
        end
    endtask

    task automatic test_reset();
        logic ok;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (sq_req !== 1'b0 || bus.res_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0 ||
            bus.in_ready !== 1'b0 || sq_in !== '0 || bus.res_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: req=%b valid=%b terr=%b busy=%b rdy=%b in=%0h data=%0h expected all 0",
                     sq_req, bus.res_valid, timeout_err, busy, bus.in_ready, sq_in, bus.res_data);
        end
        rst = 1'b0;
        wait_ready(ok);
    endtask

    task automatic test_basic();
        run_op(32'd10454520, 0);
    endtask

    task automatic test_back_to_back();
        run_op(32'd0, 0);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b expected 1", bus.in_ready);
        end
        run_op(32'hFFFF_FFFF, 0);
    endtask

    task automatic test_backpressure();
        run_op(32'd1_000_000, 10);
    endtask

    task automatic test_random();
        logic [31:0] edges [7];
        edges[0] = 32'd1;
        edges[1] = 32'd2;
        edges[2] = 32'd3;
        edges[3] = 32'd4;
        edges[4] = 32'hFFFE_0001;
        edges[5] = 32'hFFFE_0000;
        edges[6] = 32'hFFFF_FFFE;
        foreach (edges[i]) run_op(edges[i], 0);
        for (int i = 0; i < 25; i++) begin
            run_op($urandom, int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_timeout();
        logic ok;
        int   n;
        mode = MODE_NEVER;
        wait_ready(ok);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'd12345;
            @(negedge clk);
            bus.in_valid = 1'b0;
            n = 0;
            while (sq_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (timeout_err !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n !== TIMEOUT) begin
                miscompares++;
                $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT);
            end
            repeat (5) @(negedge clk);
            vectors++;
            if (timeout_err !== 1'b1 || sq_req !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_hold: terr=%b req=%b busy=%b rdy=%b expected 1/1/1/0",
                         timeout_err, sq_req, busy, bus.in_ready);
            end
        end
        apply_reset();
        mode = MODE_NORMAL;
        vectors++;
        if (timeout_err !== 1'b0 || sq_req !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: terr=%b req=%b expected 0/0", timeout_err, sq_req);
        end
    endtask

    task automatic test_reset_in_wait();
        logic ok;
        int   n;
        mode = MODE_HOLD;
        release_fin = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd777777;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (sq_fin !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sq_req !== 1'b1 || busy !== 1'b1 || sq_fin !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_wait_hi: req=%b busy=%b fin=%b expected 1/1/1", sq_req, busy, sq_fin);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (sq_req !== 1'b0 || busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            timeout_err !== 1'b0 || sq_in !== '0 || bus.res_data !== '0) begin
            miscompares++;
            $display("FAIL midop_reset: req=%b busy=%b valid=%b rdy=%b terr=%b in=%0h data=%0h expected all 0",
                     sq_req, busy, bus.res_valid, bus.in_ready, timeout_err, sq_in, bus.res_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_fin_block: rdy=%b valid=%b expected 0/0", bus.in_ready, bus.res_valid);
            end
        end
        release_fin = 1'b1;
        wait_ready(ok);
        mode = MODE_NORMAL;
        release_fin = 1'b0;
        run_op(32'd49, 2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = MODE_NORMAL;
        release_fin = 1'b0;
        rst         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_in_wait();
        test_timeout();
        run_op(32'd144, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
